// File: rtl/cmp_seq_32_pkg.sv
// Shared definitions for the nibble-serial magnitude comparator.
package cmp_seq_32_pkg;

   localparam int unsigned NIBBLE = 4;

   typedef enum logic {
      StIdle = 1'b0,
      StScan = 1'b1
   } stateT;

   // Index counter width for n nibbles; never narrower than one bit.
   function automatic int unsigned idxWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_seq_32_if.sv
// Request/result bundle between a compare requester and cmp_seq_32.
interface cmp_seq_32_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             is_signed;
   logic             busy;
   logic             done;
   logic             lt;
   logic             gt;
   logic             eq;

   modport master (
      output start, a, b, is_signed,
      input  busy, done, lt, gt, eq
   );

   modport slave (
      input  start, a, b, is_signed,
      output busy, done, lt, gt, eq
   );
endinterface

// File: rtl/comparator_4bit.sv
// Combinational unsigned 4-bit magnitude comparator.
module comparator_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       lt,
   output logic       gt,
   output logic       eq
);
   assign lt = (a < b);
   assign gt = (a > b);
   assign eq = (a == b);
endmodule

// File: rtl/cmp_seq_32.sv
// Multi-cycle magnitude comparator: scans one nibble per cycle, MS nibble first,
// and stops at the first differing nibble.
module cmp_seq_32
   import cmp_seq_32_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic         clk,
   input logic         rst_n,
   cmp_seq_32_if.slave bus
);
   localparam int unsigned N  = WIDTH / NIBBLE;
   localparam int unsigned IW = idxWidth(N);
   localparam logic [IW-1:0] TopIdx = IW'(N - 1);

   stateT            stateQ, stateD;
   logic [IW-1:0]    idxQ, idxD;
   logic [WIDTH-1:0] aQ, aD;
   logic [WIDTH-1:0] bQ, bD;
   logic             signedQ, signedD;
   logic             ltQ, ltD;
   logic             gtQ, gtD;
   logic             eqQ, eqD;
   logic             doneQ, doneD;

   logic [N-1:0][NIBBLE-1:0] aNibs, bNibs;
   logic [NIBBLE-1:0]        aNib, bNib, aCmp, bCmp;
   logic                     flipSign;
   logic                     cmpLt, cmpGt, cmpEq;

   assign aNibs = aQ;
   assign bNibs = bQ;
   assign aNib  = aNibs[idxQ];
   assign bNib  = bNibs[idxQ];

   // Offset-binary: inverting both sign bits turns a signed compare into unsigned.
   assign flipSign = signedQ && (idxQ == TopIdx);
   assign aCmp     = {aNib[NIBBLE-1] ^ flipSign, aNib[NIBBLE-2:0]};
   assign bCmp     = {bNib[NIBBLE-1] ^ flipSign, bNib[NIBBLE-2:0]};

   comparator_4bit uCmp (
      .a  (aCmp),
      .b  (bCmp),
      .lt (cmpLt),
      .gt (cmpGt),
      .eq (cmpEq)
   );

   always_comb begin
      stateD  = stateQ;
      idxD    = idxQ;
      aD      = aQ;
      bD      = bQ;
      signedD = signedQ;
      ltD     = ltQ;
      gtD     = gtQ;
      eqD     = eqQ;
      doneD   = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (bus.start) begin
               stateD  = StScan;
               aD      = bus.a;
               bD      = bus.b;
               signedD = bus.is_signed;
               idxD    = TopIdx;
            end
         end
         StScan: begin
            if (!cmpEq) begin
               ltD    = cmpLt;
               gtD    = cmpGt;
               eqD    = 1'b0;
               doneD  = 1'b1;
               stateD = StIdle;
            end else if (idxQ == '0) begin
               ltD    = 1'b0;
               gtD    = 1'b0;
               eqD    = 1'b1;
               doneD  = 1'b1;
               stateD = StIdle;
            end else begin
               idxD = idxQ - IW'(1);
            end
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ  <= StIdle;
         idxQ    <= '0;
         aQ      <= '0;
         bQ      <= '0;
         signedQ <= 1'b0;
         ltQ     <= 1'b0;
         gtQ     <= 1'b0;
         eqQ     <= 1'b0;
         doneQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         idxQ    <= idxD;
         aQ      <= aD;
         bQ      <= bD;
         signedQ <= signedD;
         ltQ     <= ltD;
         gtQ     <= gtD;
         eqQ     <= eqD;
         doneQ   <= doneD;
      end
   end

   assign bus.busy = (stateQ == StScan);
   assign bus.done = doneQ;
   assign bus.lt   = ltQ;
   assign bus.gt   = gtQ;
   assign bus.eq   = eqQ;

endmodule
